pipe_ctrl: RTL and testbench

Pipeline stall/flush sequencer for the 5-stage ARM core. It merges three sources into one consistent set of stage-register enables and flushes: the hazard unit's freeze, multi-cycle SRAM accesses from the MEM stage, and taken branches resolved in EXE. It also owns the SRAM start handshake, a memory-wait timeout that latches a fault, and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_wait_timer.sv | 30 +++
 rtl/pipe_ctrl.sv | 90 +++++++++
 tb/tb_pipe_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  localparam int DEFAULT_MEM_TIMEOUT = 64;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic exe_mem_en;
    logic mem_wb_en;
    logic flush_if_id;
    logic flush_id_exe;
  } pipe_ctl_t;

  // A taken branch beats a freeze: the frozen ID instruction is wrong-path anyway.
  function automatic pipe_ctl_t issue_ctl(input logic branch, input logic hazard);
    pipe_ctl_t c;
    c = '{default: 1'b1};
    c.flush_if_id  = 1'b0;
    c.flush_id_exe = 1'b0;
    if (branch) begin
      c.flush_if_id  = 1'b1;
      c.flush_id_exe = 1'b1;
    end else if (hazard) begin
      c.pc_en        = 1'b0;
      c.if_id_en     = 1'b0;
      c.flush_id_exe = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/memory inputs and stage-control outputs of pipe_ctrl
interface pipe_ctrl_if #(parameter int CNT_W = 16);
  logic             hazard_freeze;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_exe_en;
  logic             exe_mem_en;
  logic             mem_wb_en;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             mem_start;
  logic             fault;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hazard_freeze, branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
    input  flush_if_id, flush_id_exe, mem_start, fault, stall_cnt
  );

  modport slave (
    input  hazard_freeze, branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
    output flush_if_id, flush_id_exe, mem_start, fault, stall_cnt
  );
endinterface

// File: rtl/pipe_wait_timer.sv
// rtl/pipe_wait_timer.sv - loadable/clearable up-counter with terminal-count flag
module pipe_wait_timer #(
  parameter int LIMIT = 64,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && count != W'(LIMIT)) begin
      count <= count + W'(1);
    end
  end

  // High when the next increment brings the count to LIMIT.
  assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer merging hazard, SRAM wait and branch flush
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  pipe_ctl_t        ctl;
  logic             mem_start;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_tc;
  logic [CNT_W-1:0] stall_q;

  always_comb begin
    ctl       = '0;
    mem_start = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    state_d   = state_q;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (bus.mem_req) begin
            mem_start = 1'b1;
            tmr_clr   = 1'b1;
            state_d   = MEM_WAIT;
          end else begin
            ctl = issue_ctl(bus.branch_taken, bus.hazard_freeze);
          end
        end
        MEM_WAIT: begin
          // A ready arriving on the cycle that would time out still wins.
          if (bus.mem_ready) begin
            ctl     = issue_ctl(bus.branch_taken, bus.hazard_freeze);
            state_d = RUN;
          end else begin
            tmr_inc = 1'b1;
            if (tmr_tc) state_d = FAULT;
          end
        end
        default: state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (!ctl.pc_en && stall_q != {CNT_W{1'b1}}) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  pipe_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     ($clog2(MEM_TIMEOUT + 1))
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (tmr_inc),
    .tc       (tmr_tc)
  );

  assign bus.pc_en        = ctl.pc_en;
  assign bus.if_id_en     = ctl.if_id_en;
  assign bus.id_exe_en    = ctl.id_exe_en;
  assign bus.exe_mem_en   = ctl.exe_mem_en;
  assign bus.mem_wb_en    = ctl.mem_wb_en;
  assign bus.flush_if_id  = ctl.flush_if_id;
  assign bus.flush_id_exe = ctl.flush_id_exe;
  assign bus.mem_start    = mem_start;
  assign bus.fault        = (state_q == FAULT);
  assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  localparam int TMO   = 4;
  localparam int CW    = 3;
  localparam int SAT   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int m_mode  = 0;   // 0 run, 1 waiting on memory, 2 faulted
  int m_waits = 0;
  int m_stall = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus();

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pc, if_id, id_exe, exe_mem, mem_wb} enables and {if_id, id_exe} flushes
  function automatic logic [6:0] advance(input logic b, input logic h);
    if (b)      return 7'b11111_11;
    else if (h) return 7'b00111_01;
    else        return 7'b11111_00;
  endfunction

  task automatic cycle(input logic r, input logic h, input logic b,
                       input logic mq, input logic rdy);
    logic [6:0] e_ctl;
    logic       e_start;
    rst_n             = r;
    bus.hazard_freeze = h;
    bus.branch_taken  = b;
    bus.mem_req       = mq;
    bus.mem_ready     = rdy;
    e_ctl   = 7'd0;
    e_start = 1'b0;
    if (r) begin
      if (m_mode == 0) begin
        if (mq) e_start = 1'b1;
        else    e_ctl   = advance(b, h);
      end else if (m_mode == 1 && rdy) begin
        e_ctl = advance(b, h);
      end
    end
    @(negedge clk);
    check("enables", {bus.pc_en, bus.if_id_en, bus.id_exe_en, bus.exe_mem_en, bus.mem_wb_en},
          e_ctl[6:2]);
    check("flushes", {bus.flush_if_id, bus.flush_id_exe}, e_ctl[1:0]);
    check("mem_start", bus.mem_start, e_start);
    check("fault", bus.fault, (m_mode == 2));
    check("stall_cnt", bus.stall_cnt, m_stall);
    @(posedge clk);
    #1;
    if (!r) begin
      m_mode = 0; m_waits = 0; m_stall = 0;
    end else begin
      if (!e_ctl[6] && m_stall < SAT) m_stall++;
      if (m_mode == 0 && mq) begin
        m_mode = 1; m_waits = 0;
      end else if (m_mode == 1) begin
        if (rdy) m_mode = 0;
        else begin
          m_waits++;
          if (m_waits == TMO) m_mode = 2;
        end
      end
    end
  endtask

  initial begin
    bus.hazard_freeze = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.mem_req       = 1'b1;
    bus.mem_ready     = 1'b1;
    @(posedge clk);
    #1;

    // reset with all inputs high, then idle issue
    repeat (3) cycle(0, 1, 1, 1, 1);
    check("rst_stall", bus.stall_cnt, 0);
    cycle(1, 0, 0, 0, 0);

    // hazard for two cycles, then branch overriding the freeze
    repeat (2) cycle(1, 1, 0, 0, 0);
    check("hazard_stall", bus.stall_cnt, 2);
    cycle(1, 1, 1, 0, 0);

    // memory access with three wait cycles, then back-to-back request
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    repeat (3) cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    check("mem_stall", bus.stall_cnt, 4);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1);

    // branch held across a memory wait
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 1, 1, 1);

    // timeout into sticky fault
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);
    check("fault_set", bus.fault, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (2) cycle(1, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 0);
    check("fault_clear", bus.fault, 0);

    // stall counter saturation
    repeat (10) cycle(1, 1, 0, 0, 0);
    check("stall_sat", bus.stall_cnt, SAT);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(40) != 0, 1'($urandom_range(1)), $urandom_range(3) == 0,
            1'($urandom_range(1)), $urandom_range(3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
